// File: rtl/sobel_stream.sv
`default_nettype none
// ============================================================================
// Module   : sobel_stream
// Brief    : Streaming 3x3 Sobel gradient magnitude over raster frames, using
//            two line buffers and zero padding on every border. Defining
//            SOBEL_THRESHOLD_EN adds a thresh port and makes the output binary.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_stream #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int PIX_W = 8,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [PIX_W-1:0] thresh,
`endif
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_last,
    output logic             frame_done,
    output logic             busy
);
    localparam int GW = PIX_W + 4;
    localparam int AW = $clog2(IMG_W);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_LAST_COL  = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] c_LAST_ROW  = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] c_FLUSH_END = CNT_W'(IMG_W);
    localparam logic [GW-1:0]    c_PIX_MAX   = GW'((1 << PIX_W) - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] in_row_q, in_row_d, in_col_q, in_col_d;
    logic [CNT_W-1:0] cen_row_q, cen_row_d, cen_col_q, cen_col_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             flush_done_q, flush_done_d;

    logic             w_advance, w_in_stream, w_accept, w_inject, w_shift, w_centred;
    logic [PIX_W-1:0] w_pix_in, w_col_top, w_col_mid;
    logic [AW-1:0]    w_lb_addr;

    logic [PIX_W-1:0] lb_top_q [IMG_W];
    logic [PIX_W-1:0] lb_mid_q [IMG_W];
    logic [PIX_W-1:0] win_q [3][3];

    logic                 v0_q, top_q, left_q, right_q, last0_q;
    logic                 v1_q, last1_q;
    logic signed [GW-1:0] gx_q, gy_q, w_gx, w_gy;
    logic                 m_valid_q, m_last_q;
    logic [PIX_W-1:0]     m_data_q, w_clamp, w_result;
    logic [GW-1:0]        w_abs_x, w_abs_y, w_mag;

    assign w_advance   = !m_valid_q || m_ready;
    assign w_in_stream = (state_q == ST_IDLE) || (state_q == ST_FILL) || (state_q == ST_RUN);
    assign s_ready     = reset && w_advance && w_in_stream;
    assign w_accept    = s_valid && s_ready;
    assign w_inject    = reset && w_advance && (state_q == ST_FLUSH) && !flush_done_q;
    assign w_shift     = w_accept || w_inject;
    assign w_pix_in    = w_inject ? '0 : s_data;
    assign w_centred   = (state_q == ST_RUN) || (state_q == ST_FLUSH);

    always_comb begin
        state_d      = state_q;
        in_row_d     = in_row_q;
        in_col_d     = in_col_q;
        cen_row_d    = cen_row_q;
        cen_col_d    = cen_col_q;
        flush_cnt_d  = flush_cnt_q;
        flush_done_d = flush_done_q;
        frame_done   = 1'b0;
        busy         = 1'b0;

        if (w_shift) begin
            if (in_col_q == c_LAST_COL) begin
                in_col_d = '0;
                in_row_d = in_row_q + c_ONE;
            end else begin
                in_col_d = in_col_q + c_ONE;
            end
            if (w_centred) begin
                if (cen_col_q == c_LAST_COL) begin
                    cen_col_d = '0;
                    cen_row_d = (cen_row_q == c_LAST_ROW) ? '0 : cen_row_q + c_ONE;
                end else begin
                    cen_col_d = cen_col_q + c_ONE;
                end
            end
        end
        if (w_inject) begin
            if (flush_cnt_q == c_FLUSH_END) flush_done_d = 1'b1;
            else                            flush_cnt_d  = flush_cnt_q + c_ONE;
        end

        case (state_q)
            ST_IDLE: if (w_accept) state_d = ST_FILL;
            ST_FILL: begin
                busy = 1'b1;
                if (w_accept && in_row_q == c_ONE && in_col_q == '0) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_accept && in_row_q == c_LAST_ROW && in_col_q == c_LAST_COL) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (flush_done_q && m_valid_q && m_ready && m_last_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                frame_done   = 1'b1;
                state_d      = ST_IDLE;
                in_row_d     = '0;
                in_col_d     = '0;
                cen_row_d    = '0;
                cen_col_d    = '0;
                flush_cnt_d  = '0;
                flush_done_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line buffers: top holds the row two back, mid the row one back.
    assign w_lb_addr = in_col_q[AW-1:0];
    assign w_col_top = lb_top_q[w_lb_addr];
    assign w_col_mid = lb_mid_q[w_lb_addr];

    always_ff @(posedge clk) begin
        if (w_shift) begin
            lb_top_q[w_lb_addr] <= w_col_mid;
            lb_mid_q[w_lb_addr] <= w_pix_in;
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= w_col_top;
            win_q[1][2] <= w_col_mid;
            win_q[2][2] <= w_pix_in;
        end
    end

    // Edge columns hold pixels of the neighbouring line, so they are masked by centre position.
    function automatic logic signed [GW-1:0] tap(input logic [PIX_W-1:0] pix, input logic kill);
        return kill ? '0 : GW'(pix);
    endfunction

    assign w_gx = (tap(win_q[0][2], top_q || right_q) + (tap(win_q[1][2], right_q) <<< 1)
                   + tap(win_q[2][2], right_q))
                - (tap(win_q[0][0], top_q || left_q) + (tap(win_q[1][0], left_q) <<< 1)
                   + tap(win_q[2][0], left_q));
    assign w_gy = (tap(win_q[2][0], left_q) + (tap(win_q[2][1], 1'b0) <<< 1)
                   + tap(win_q[2][2], right_q))
                - (tap(win_q[0][0], top_q || left_q) + (tap(win_q[0][1], top_q) <<< 1)
                   + tap(win_q[0][2], top_q || right_q));

    assign w_abs_x = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    assign w_abs_y = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    assign w_mag   = w_abs_x + w_abs_y;
    assign w_clamp = (w_mag > c_PIX_MAX) ? '1 : w_mag[PIX_W-1:0];
`ifdef SOBEL_THRESHOLD_EN
    assign w_result = (w_clamp >= thresh) ? '1 : '0;
`else
    assign w_result = w_clamp;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            in_row_q     <= '0;
            in_col_q     <= '0;
            cen_row_q    <= '0;
            cen_col_q    <= '0;
            flush_cnt_q  <= '0;
            flush_done_q <= 1'b0;
            v0_q         <= 1'b0;
            top_q        <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            last0_q      <= 1'b0;
            v1_q         <= 1'b0;
            last1_q      <= 1'b0;
            gx_q         <= '0;
            gy_q         <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            in_row_q     <= in_row_d;
            in_col_q     <= in_col_d;
            cen_row_q    <= cen_row_d;
            cen_col_q    <= cen_col_d;
            flush_cnt_q  <= flush_cnt_d;
            flush_done_q <= flush_done_d;
            if (w_advance) begin
                v0_q <= w_shift && w_centred;
                if (w_shift) begin
                    top_q   <= (cen_row_q == '0);
                    left_q  <= (cen_col_q == '0);
                    right_q <= (cen_col_q == c_LAST_COL);
                    last0_q <= (cen_row_q == c_LAST_ROW) && (cen_col_q == c_LAST_COL);
                end
                v1_q      <= v0_q;
                last1_q   <= v0_q && last0_q;
                gx_q      <= w_gx;
                gy_q      <= w_gy;
                m_valid_q <= v1_q;
                m_last_q  <= v1_q && last1_q;
                m_data_q  <= w_result;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_stream
// Brief    : Self-checking bench for sobel_stream (8x4 frames) against a
//            direct arithmetic Sobel model; honours SOBEL_THRESHOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_stream;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int P    = 8;
    localparam int C    = 10;
    localparam int NPIX = W * H;

    logic         clk     = 1'b0;
    logic         reset   = 1'b0;
    logic         s_valid = 1'b0;
    logic         m_ready = 1'b1;
    logic [P-1:0] s_data  = '0;
    logic         s_ready, m_valid, m_last, frame_done, busy;
    logic [P-1:0] m_data;
`ifdef SOBEL_THRESHOLD_EN
    logic [P-1:0] thresh = 8'd128;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int img     [H][W];
    int got     [NPIX];
    int acc_cyc [NPIX];
    int first_valid_cyc;

    sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .CNT_W(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
`ifdef SOBEL_THRESHOLD_EN
        .thresh     (thresh),
`endif
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int thr(int v);
`ifdef SOBEL_THRESHOLD_EN
        return (v >= int'(thresh)) ? 255 : 0;
`else
        return v;
`endif
    endfunction

    function automatic int px(int r, int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 0;
        return img[r][c];
    endfunction

    function automatic int ref_out(int r, int c);
        int gx, gy, m;
        gx = (px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1))
           - (px(r-1, c-1) + 2*px(r, c-1) + px(r+1, c-1));
        gy = (px(r+1, c-1) + 2*px(r+1, c) + px(r+1, c+1))
           - (px(r-1, c-1) + 2*px(r-1, c) + px(r-1, c+1));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
        return thr(m);
    endfunction

    task automatic fill_img(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (mode)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = c;
                    2:       img[r][c] = (c < 4) ? 0 : 200;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    task automatic spot(input int r, input int c, input int v);
        check($sformatf("spot(%0d,%0d)", r, c), got[r*W + c], thr(v));
    endtask

    task automatic run_frame(input bit bp, input bit chk_lat);
        int idx, nout, cyc;
        bit stalled, busy_seen;
        logic [P-1:0] held_d;
        logic held_l;
        idx = 0; nout = 0; cyc = 0; stalled = 0; busy_seen = 0;
        held_d = '0; held_l = 1'b0; first_valid_cyc = -1;
        while (nout < NPIX && cyc < 3000) begin
            @(negedge clk);
            s_valid = (idx < NPIX) && (!bp || $urandom_range(0, 3) != 0);
            s_data  = (idx < NPIX) ? P'(img[idx / W][idx % W]) : '0;
            m_ready = !bp || ($urandom_range(0, 1) == 1);
            #1;
            if (stalled) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, held_d);
                check("stall_last", m_last, held_l);
            end
            if (idx == NPIX / 2 && !busy_seen) begin
                check("busy_mid", busy, 1);
                busy_seen = 1;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (s_valid && s_ready) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            if (m_valid && m_ready) begin
                got[nout] = int'(m_data);
                check($sformatf("out(%0d,%0d)", nout / W, nout % W), m_data, ref_out(nout / W, nout % W));
                check("m_last", m_last, (nout == NPIX - 1));
                nout++;
            end
            stalled = m_valid && !m_ready;
            held_d  = m_data;
            held_l  = m_last;
            cyc++;
        end
        check("frame_outputs", nout, NPIX);
        // Accept edge -> window, gx/gy, then m_valid one edge later: seen 3 samples on.
        if (chk_lat) check("latency", first_valid_cyc - acc_cyc[W + 1], 3);
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        #1;
        check("frame_done", frame_done, 1);
        check("m_valid_after_last", m_valid, 0);
        @(negedge clk);
        #1;
        check("frame_done_pulse", frame_done, 0);
        check("busy_idle", busy, 0);
        check("m_valid_idle", m_valid, 0);
    endtask

    task automatic abort_frame(input int npix);
        int k, cyc;
        k = 0; cyc = 0;
        m_ready = 1'b1;
        while (k < npix && cyc < 200) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = P'(img[k / W][k % W]);
            #1;
            if (s_ready) k++;
            cyc++;
        end
        check("abort_accepted", k, npix);
        @(negedge clk);
        s_valid = 1'b0;
        reset   = 1'b0;
        #1;
        check("s_ready_in_reset", s_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("m_valid_after_reset", m_valid, 0);
        check("busy_after_reset", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 0);
        @(negedge clk);
        reset = 1'b1;

        fill_img(0);
        run_frame(1'b0, 1'b1);
        spot(0, 0, 255); spot(0, 3, 255); spot(1, 3, 0); spot(2, 4, 0); spot(1, 0, 255);

        fill_img(1);
        run_frame(1'b0, 1'b0);
        for (int r = 1; r <= 2; r++)
            for (int c = 1; c <= 6; c++)
                spot(r, c, 8);
        spot(1, 7, 24); spot(1, 0, 4);

        fill_img(2);
        run_frame(1'b0, 1'b0);
        spot(1, 3, 255); spot(1, 4, 255); spot(1, 2, 0); spot(2, 5, 0);

        run_frame(1'b1, 1'b0);
        spot(1, 3, 255); spot(1, 2, 0);

        fill_img(3);
        run_frame(1'b1, 1'b0);

        abort_frame(13);
        fill_img(3);
        run_frame(1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
